// File: rtl/display_vga_out_if.sv
// display_vga_out_if: timing, position, colour and pattern-select bundle for display_vga_out
interface display_vga_out_if #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 4
);
    logic                i_hs;
    logic                i_vs;
    logic                i_de;
    logic                i_frame;
    logic signed [15:0]  i_x;
    logic signed [15:0]  i_y;
    logic [IN_BITS-1:0]  i_red;
    logic [IN_BITS-1:0]  i_green;
    logic [IN_BITS-1:0]  i_blue;
    logic [1:0]          i_mode;
    logic                o_hs;
    logic                o_vs;
    logic                o_de;
    logic [OUT_BITS-1:0] o_red;
    logic [OUT_BITS-1:0] o_green;
    logic [OUT_BITS-1:0] o_blue;

    modport master (
        output i_hs, i_vs, i_de, i_frame, i_x, i_y, i_red, i_green, i_blue, i_mode,
        input  o_hs, o_vs, o_de, o_red, o_green, o_blue
    );

    modport slave (
        input  i_hs, i_vs, i_de, i_frame, i_x, i_y, i_red, i_green, i_blue, i_mode,
        output o_hs, o_vs, o_de, o_red, o_green, o_blue
    );
endinterface

// File: rtl/display_vga_out.sv
// display_vga_out: registered VGA output stage with test patterns, quantise and blanking;
// optional 2x2 ordered dither enabled by DISPLAY_VGA_OUT_DITHER_EN
module display_vga_out #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 4,
    parameter int H_RES    = 640,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0
) (
    input logic              i_pixclk,
    input logic              i_rst,
    display_vga_out_if.slave vga
);
    localparam int BAR_W = H_RES / 8;
    localparam logic [IN_BITS-1:0] MID = {1'b1, {(IN_BITS-1){1'b0}}};

    logic [1:0]          mode_q;
    logic [15:0]         p;
    logic [15:0]         xu;
    logic [2:0]          bar;
    logic                on_line;
    logic [IN_BITS-1:0]  r_sel, g_sel, b_sel;
    logic                hs1, vs1, de1;
    logic [IN_BITS-1:0]  r1, g1, b1;
    logic [OUT_BITS-1:0] q_r, q_g, q_b;
    logic                hs2, vs2, de2;
    logic [OUT_BITS-1:0] r2, g2, b2;
    logic                unused_bits;

    // bar colours follow {r,g,b} = ~{bar[1], bar[2], bar[0]}
    always_comb begin
        xu = vga.i_x;
        bar = '0;
        for (int k = 1; k < 8; k++)
            if (xu >= 16'(k * BAR_W)) bar = 3'(k);
        on_line = (xu >= p) && ({1'b0, xu} <= {1'b0, p} + 17'd7);
        r_sel = !vga.i_de ? '0 : mode_q == 2'd0 ? vga.i_red :
                mode_q == 2'd1 ? {IN_BITS{~bar[1]}} : mode_q == 2'd2 ? {IN_BITS{on_line}} : MID;
        g_sel = !vga.i_de ? '0 : mode_q == 2'd0 ? vga.i_green :
                mode_q == 2'd1 ? {IN_BITS{~bar[2]}} : mode_q == 2'd2 ? {IN_BITS{on_line}} : MID;
        b_sel = !vga.i_de ? '0 : mode_q == 2'd0 ? vga.i_blue :
                mode_q == 2'd1 ? {IN_BITS{~bar[0]}} : mode_q == 2'd2 ? {IN_BITS{on_line}} : MID;
    end

    always_ff @(posedge i_pixclk) begin
        if (i_rst) begin
            mode_q <= '0;
            p      <= '0;
            hs1    <= ~H_POL;
            vs1    <= ~V_POL;
            de1    <= 1'b0;
            r1     <= '0;
            g1     <= '0;
            b1     <= '0;
        end else begin
            if (vga.i_frame) begin
                mode_q <= vga.i_mode;
                p      <= (p >= 16'(H_RES - 8)) ? '0 : p + 16'd4;
            end
            hs1 <= vga.i_hs;
            vs1 <= vga.i_vs;
            de1 <= vga.i_de;
            r1  <= r_sel;
            g1  <= g_sel;
            b1  <= b_sel;
        end
    end

`ifdef DISPLAY_VGA_OUT_DITHER_EN
    localparam int SH = (IN_BITS - OUT_BITS >= 2) ? IN_BITS - OUT_BITS - 2 : 0;

    if (IN_BITS - OUT_BITS < 2) begin : g_bad_dither
        $error("display_vga_out: dithering needs IN_BITS - OUT_BITS >= 2");
    end

    logic [1:0] t1;

    // threshold map {y0,x0}: 00->0, 01->2, 10->3, 11->1
    always_ff @(posedge i_pixclk) begin
        if (i_rst) t1 <= '0;
        else t1 <= {vga.i_x[0] ^ vga.i_y[0], vga.i_y[0]};
    end

    function automatic logic [OUT_BITS-1:0] quant(input logic [IN_BITS-1:0] c, input logic [1:0] t);
        logic [IN_BITS:0] s;
        s = {1'b0, c} + ({{(IN_BITS-1){1'b0}}, t} << SH);
        return s[IN_BITS] ? {OUT_BITS{1'b1}} : s[IN_BITS-1 -: OUT_BITS];
    endfunction

    assign q_r = quant(r1, t1);
    assign q_g = quant(g1, t1);
    assign q_b = quant(b1, t1);
    assign unused_bits = ^vga.i_y[15:1];
`else
    assign q_r = r1[IN_BITS-1 -: OUT_BITS];
    assign q_g = g1[IN_BITS-1 -: OUT_BITS];
    assign q_b = b1[IN_BITS-1 -: OUT_BITS];
    assign unused_bits = ^{vga.i_y, r1, g1, b1};
`endif

    always_ff @(posedge i_pixclk) begin
        if (i_rst) begin
            hs2 <= ~H_POL;
            vs2 <= ~V_POL;
            de2 <= 1'b0;
            r2  <= '0;
            g2  <= '0;
            b2  <= '0;
        end else begin
            hs2 <= hs1;
            vs2 <= vs1;
            de2 <= de1;
            r2  <= de1 ? q_r : '0;
            g2  <= de1 ? q_g : '0;
            b2  <= de1 ? q_b : '0;
        end
    end

    assign vga.o_hs    = hs2;
    assign vga.o_vs    = vs2;
    assign vga.o_de    = de2;
    assign vga.o_red   = r2;
    assign vga.o_green = g2;
    assign vga.o_blue  = b2;
endmodule

// File: tb/tb_display_vga_out.sv
// tb_display_vga_out: directed self-checking bench for display_vga_out (H_RES=640, 8->4 bits)
module tb_display_vga_out;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          total = 0;
    int          bad = 0;
    logic [15:0] p_model = '0;

    display_vga_out_if #(.IN_BITS(8), .OUT_BITS(4)) vga ();

    display_vga_out #(
        .IN_BITS(8), .OUT_BITS(4), .H_RES(640), .H_POL(1'b0), .V_POL(1'b0)
    ) dut (
        .i_pixclk(clk),
        .i_rst(rst),
        .vga(vga)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic de, input logic [15:0] x, input logic [15:0] y,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        vga.i_de = de;
        vga.i_x = x;
        vga.i_y = y;
        vga.i_red = r;
        vga.i_green = g;
        vga.i_blue = b;
    endtask

    task automatic frame(input logic [1:0] m);
        vga.i_de = 1'b0;
        vga.i_mode = m;
        vga.i_frame = 1'b1;
        step;
        vga.i_frame = 1'b0;
        p_model = (p_model >= 16'd632) ? 16'd0 : p_model + 16'd4;
    endtask

    task automatic test_reset;
        drive(1'b1, 16'd5, 16'd0, 8'hFF, 8'h00, 8'h00);
        vga.i_hs = 1'b0;
        vga.i_vs = 1'b0;
        rst = 1'b1;
        repeat (3) step;
        total += 4;
        if (vga.o_red !== 4'h0) begin bad++; $display("FAIL reset_red got %h want 0", vga.o_red); end
        if (vga.o_hs !== 1'b1) begin bad++; $display("FAIL reset_hs got %b want 1", vga.o_hs); end
        if (vga.o_vs !== 1'b1) begin bad++; $display("FAIL reset_vs got %b want 1", vga.o_vs); end
        if (vga.o_de !== 1'b0) begin bad++; $display("FAIL reset_de got %b want 0", vga.o_de); end
        rst = 1'b0;
        step;
        total++;
        if (vga.o_red !== 4'h0) begin bad++; $display("FAIL latency_early got %h want 0", vga.o_red); end
        step;
        total += 2;
        if (vga.o_red !== 4'hF) begin bad++; $display("FAIL latency_red got %h want f", vga.o_red); end
        if (vga.o_hs !== 1'b0) begin bad++; $display("FAIL latency_hs got %b want 0", vga.o_hs); end
    endtask

    task automatic test_mode_latch;
        drive(1'b1, 16'd10, 16'd3, 8'h35, 8'hA0, 8'h5C);
        vga.i_mode = 2'd3;
        step;
        step;
        total++;
        if ({vga.o_red, vga.o_green, vga.o_blue} !== 12'h3A5)
            begin bad++; $display("FAIL latch_midline got %h want 3a5", {vga.o_red, vga.o_green, vga.o_blue}); end
        vga.i_frame = 1'b1;
        step;
        vga.i_frame = 1'b0;
        p_model = p_model + 16'd4;
        step;
        total++;
        if ({vga.o_red, vga.o_green, vga.o_blue} !== 12'h3A5)
            begin bad++; $display("FAIL latch_frame_pixel got %h want 3a5", {vga.o_red, vga.o_green, vga.o_blue}); end
        step;
        total++;
        if ({vga.o_red, vga.o_green, vga.o_blue} !== 12'h888)
            begin bad++; $display("FAIL latch_grey got %h want 888", {vga.o_red, vga.o_green, vga.o_blue}); end
    endtask

    task automatic test_bars;
        logic [15:0] xs [7] = '{16'd79, 16'd80, 16'd200, 16'd400, 16'd560, 16'd639, 16'd79};
        logic        des [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [11:0] exp [7] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'hF00, 12'h000, 12'h000, 12'h000};
        frame(2'd1);
        for (int i = 0; i < 7; i++) begin
            drive(des[i], xs[i], 16'd7, 8'h12, 8'h34, 8'h56);
            step;
            step;
            total++;
            if ({vga.o_red, vga.o_green, vga.o_blue} !== exp[i]) begin
                bad++;
                $display("FAIL bars x=%0d de=%b got %h want %h", xs[i], des[i],
                         {vga.o_red, vga.o_green, vga.o_blue}, exp[i]);
            end
        end
    endtask

    task automatic test_line;
        logic [15:0] xs [7] = '{16'd624, 16'd631, 16'd632, 16'd639, 16'd0, 16'd7, 16'd8};
        logic [11:0] exp [7] = '{12'h000, 12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000};
        frame(2'd2);
        for (int n = 0; n < 200 && p_model != 16'd632; n++) frame(2'd2);
        for (int i = 0; i < 7; i++) begin
            if (i == 4) frame(2'd2);
            drive(1'b1, xs[i], 16'd1, 8'h00, 8'h00, 8'h00);
            step;
            step;
            total++;
            if ({vga.o_red, vga.o_green, vga.o_blue} !== exp[i]) begin
                bad++;
                $display("FAIL line x=%0d p=%0d got %h want %h", xs[i], p_model,
                         {vga.o_red, vga.o_green, vga.o_blue}, exp[i]);
            end
        end
    endtask

    task automatic test_dither;
        logic [15:0] xs [7] = '{16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd2, 16'd3};
        logic [15:0] ys [7] = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd0};
        logic [7:0]  cs [7] = '{8'h07, 8'h07, 8'h07, 8'h07, 8'hFC, 8'h84, 8'h7A};
`ifdef DISPLAY_VGA_OUT_DITHER_EN
        logic [3:0]  exp [7] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'hF, 4'h9, 4'h8};
`else
        logic [3:0]  exp [7] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h8, 4'h7};
`endif
        frame(2'd0);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, xs[i], ys[i], cs[i], cs[i], cs[i]);
            step;
            step;
            total++;
            if ({vga.o_red, vga.o_green, vga.o_blue} !== {exp[i], exp[i], exp[i]}) begin
                bad++;
                $display("FAIL quant x=%0d y=%0d c=%h got %h want %h", xs[i], ys[i], cs[i],
                         {vga.o_red, vga.o_green, vga.o_blue}, {exp[i], exp[i], exp[i]});
            end
        end
    endtask

    task automatic test_sync;
        logic [2:0] prev = 3'b000;
        logic [2:0] cur;
        int         shown = 0;
        for (int i = 0; i < 10000; i++) begin
            cur = 3'($urandom_range(0, 7));
            vga.i_hs = cur[2];
            vga.i_vs = cur[1];
            vga.i_de = cur[0];
            step;
            if (i > 0) begin
                total++;
                if ({vga.o_hs, vga.o_vs, vga.o_de} !== prev) begin
                    bad++;
                    if (shown < 5) begin
                        shown++;
                        $display("FAIL sync cycle=%0d got %b want %b", i, {vga.o_hs, vga.o_vs, vga.o_de}, prev);
                    end
                end
            end
            prev = cur;
        end
    endtask

    initial begin
        vga.i_hs = 1'b1;
        vga.i_vs = 1'b1;
        vga.i_de = 1'b0;
        vga.i_frame = 1'b0;
        vga.i_x = '0;
        vga.i_y = '0;
        vga.i_red = '0;
        vga.i_green = '0;
        vga.i_blue = '0;
        vga.i_mode = 2'd0;
        test_reset;
        test_mode_latch;
        test_bars;
        test_line;
        test_dither;
        test_sync;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
